// File: rtl/life_board.sv
// rtl/life_board.sv - Game of Life cell store with edit painting and timed generation stepping.
// Optional build macro LIFE_WRAP_EN selects a toroidal grid; undefined treats off-grid cells as dead.
module life_board #(
  parameter int WIDTH       = 8,
  parameter int HEIGHT      = 8,
  parameter int TICK_CYCLES = 4,
  parameter int GEN_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           write_en,
  input  logic                           set_cell,
  input  logic                           clear,
  input  logic [WIDTH-1:0][HEIGHT-1:0]   cursor,
  output logic [WIDTH-1:0][HEIGHT-1:0]   board,
  output logic [GEN_W-1:0]               gen_count,
  output logic                           step_done,
  output logic                           running
);

  localparam int CW = $clog2(TICK_CYCLES + 1);

  typedef enum logic [1:0] {EDIT, RUN_WAIT, RUN_STEP} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           do_step;
  logic [WIDTH-1:0][HEIGHT-1:0]   next_board;

  function automatic logic [3:0] count8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Neighbour indices are elaboration constants; validity masks kill off-grid cells when not wrapping.
  for (genvar gx = 0; gx < WIDTH; gx++) begin : g_col
    for (genvar gy = 0; gy < HEIGHT; gy++) begin : g_cell
      localparam int XM = (gx == 0) ? WIDTH - 1 : gx - 1;
      localparam int XP = (gx == WIDTH - 1) ? 0 : gx + 1;
      localparam int YM = (gy == 0) ? HEIGHT - 1 : gy - 1;
      localparam int YP = (gy == HEIGHT - 1) ? 0 : gy + 1;
`ifdef LIFE_WRAP_EN
      localparam bit VXM = 1'b1;
      localparam bit VXP = 1'b1;
      localparam bit VYM = 1'b1;
      localparam bit VYP = 1'b1;
`else
      localparam bit VXM = (gx != 0);
      localparam bit VXP = (gx != WIDTH - 1);
      localparam bit VYM = (gy != 0);
      localparam bit VYP = (gy != HEIGHT - 1);
`endif
      logic [7:0] nb;
      logic [3:0] n;
      assign nb = {board[XM][YM] & VXM & VYM,
                   board[XM][gy] & VXM,
                   board[XM][YP] & VXM & VYP,
                   board[gx][YM] & VYM,
                   board[gx][YP] & VYP,
                   board[XP][YM] & VXP & VYM,
                   board[XP][gy] & VXP,
                   board[XP][YP] & VXP & VYP};
      assign n = count8(nb);
      assign next_board[gx][gy] = (n == 4'd3) | (board[gx][gy] & (n == 4'd2));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    do_step = 1'b0;
    if (write_en) begin
      state_d = EDIT;
    end else begin
      case (state_q)
        EDIT: begin
          state_d = RUN_WAIT;
          cnt_d   = '0;
        end
        RUN_WAIT: begin
          if (cnt_q == CW'(TICK_CYCLES - 1)) begin
            state_d = RUN_STEP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN_STEP: begin
          state_d = RUN_WAIT;
          cnt_d   = '0;
          do_step = 1'b1;
        end
        default: begin
          state_d = EDIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EDIT;
      cnt_q     <= '0;
      board     <= '0;
      gen_count <= '0;
      step_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_done <= do_step;
      if (do_step) begin
        board     <= next_board;
        gen_count <= gen_count + GEN_W'(1);
      end else if (state_q == EDIT && write_en) begin
        if (clear) begin
          board     <= '0;
          gen_count <= '0;
        end else begin
          board <= (board & ~cursor) | (set_cell ? cursor : '0);
        end
      end
    end
  end

  assign running = (state_q != EDIT);

endmodule
